// File: rtl/vga_grid_arbiter_if.sv
// Game-logic side of the grid RAM arbiter: request/grant handshake plus the
// address/data lines the snake FSM uses to read and write cell states.
interface vga_grid_arbiter_if #(
    parameter int ADDR_W = 9
);
    logic              game_req;
    logic              game_we;
    logic [ADDR_W-1:0] game_addr;
    logic [1:0]        game_wdata;
    logic              game_grant;
    logic [1:0]        game_rdata;

    // Game FSM drives requests and consumes grant/read data
    modport master (
        output game_req, game_we, game_addr, game_wdata,
        input  game_grant, game_rdata
    );

    // Arbiter receives requests and returns grant/read data
    modport slave (
        input  game_req, game_we, game_addr, game_wdata,
        output game_grant, game_rdata
    );
endinterface

// File: rtl/vga_grid_arbiter.sv
// Shares the single-port game-grid RAM between the VGA pixel fetch path and
// the snake game logic. The pixel path owns the RAM outside vertical blanking;
// the game logic gets it only during blanking through a req/grant handshake,
// and loses it a few pixels before the frame wraps so the fetch pipeline is
// primed for pixel (0,0).
module vga_grid_arbiter #(
    parameter int CELL_SHIFT = 5,
    parameter int GRID_COLS  = 20,
    parameter int GRID_ROWS  = 15,
    parameter int ADDR_W     = 9,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_TOTAL    = 525,
    parameter int GUARD      = 8
) (
    input  logic              clock_25,
    input  logic              reset,
    input  logic [9:0]        X,
    input  logic [9:0]        Y,
    input  logic              display_area,
    vga_grid_arbiter_if.slave game,
    output logic              frame_tick,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    output logic [1:0]        game_data,
    output logic              game_enable
);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_BLANK = 10'(V_ACTIVE);
    localparam logic [9:0] GUARD_X = 10'(H_TOTAL - GUARD);

    typedef enum logic [1:0] {
        ST_DISPLAY     = 2'd0,
        ST_BLANK_IDLE  = 2'd1,
        ST_GAME_ACCESS = 2'd2,
        ST_DRAIN       = 2'd3
    } state_t;

    state_t            state_q;
    logic              frame_tick_q;
    logic              fetch_d1_q;
    logic              da_d1_q;
    logic              grid_d1_q;
    logic              game_enable_q;
    logic [1:0]        game_data_q;
    logic [1:0]        game_rdata_q;

    logic [9:0]        col_s;
    logic [9:0]        row_s;
    logic [ADDR_W-1:0] pix_addr_s;
    logic              in_grid_s;
    logic              guard_s;
    logic              fetch_s;
    logic              grant_s;

    // Cell coordinates, fetch address, guard window and grant decode
    always_comb begin
        col_s      = X >> CELL_SHIFT;
        row_s      = Y >> CELL_SHIFT;
        pix_addr_s = ADDR_W'(20'(row_s) * 20'(GRID_COLS) + 20'(col_s));
        in_grid_s  = (col_s < 10'(GRID_COLS)) && (row_s < 10'(GRID_ROWS));
        guard_s    = (Y == V_LAST) && (X >= GUARD_X);
        fetch_s    = (state_q == ST_DISPLAY) || (state_q == ST_DRAIN);
        // Grant falls in the same cycle the request drops or the guard opens
        grant_s    = (state_q == ST_GAME_ACCESS) && game.game_req && !guard_s;
    end

    // RAM port mux; held at zero while reset is asserted
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 2'b00;
        if (!reset) begin
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = 2'b00;
        end else begin
            case (state_q)
                ST_DISPLAY:     mem_addr = pix_addr_s;
                ST_DRAIN:       mem_addr = pix_addr_s;
                ST_BLANK_IDLE:  mem_addr = game.game_addr;
                ST_GAME_ACCESS: begin
                    mem_addr  = game.game_addr;
                    mem_we    = grant_s & game.game_we;
                    mem_wdata = game.game_wdata;
                end
                default:        mem_addr = '0;
            endcase
        end
    end

    // Ownership FSM with the frame_tick pulse on entry to vertical blanking
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_DISPLAY;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= 1'b0;
            case (state_q)
                ST_DISPLAY: begin
                    if ((X == 10'd0) && (Y == V_BLANK)) begin
                        state_q      <= ST_BLANK_IDLE;
                        frame_tick_q <= 1'b1;
                    end else begin
                        state_q <= ST_DISPLAY;
                    end
                end
                ST_BLANK_IDLE: begin
                    if (guard_s) begin
                        state_q <= ST_DRAIN;
                    end else if (game.game_req) begin
                        state_q <= ST_GAME_ACCESS;
                    end else begin
                        state_q <= ST_BLANK_IDLE;
                    end
                end
                ST_GAME_ACCESS: begin
                    if (guard_s) begin
                        state_q <= ST_DRAIN;
                    end else if (!game.game_req) begin
                        state_q <= ST_BLANK_IDLE;
                    end else begin
                        state_q <= ST_GAME_ACCESS;
                    end
                end
                ST_DRAIN: begin
                    if ((X == H_LAST) && (Y == V_LAST)) begin
                        state_q <= ST_DISPLAY;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: state_q <= ST_DISPLAY;
            endcase
        end
    end

    // Two-stage pixel pipeline: qualifiers ride alongside the RAM read
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            fetch_d1_q    <= 1'b0;
            da_d1_q       <= 1'b0;
            grid_d1_q     <= 1'b0;
            game_enable_q <= 1'b0;
            game_data_q   <= 2'b00;
        end else begin
            fetch_d1_q    <= fetch_s;
            da_d1_q       <= display_area;
            grid_d1_q     <= in_grid_s;
            game_enable_q <= fetch_d1_q & da_d1_q & grid_d1_q;
            game_data_q   <= (fetch_d1_q & grid_d1_q) ? mem_rdata : 2'b00;
        end
    end

    // Game read data is captured on every cycle the game owns the RAM
    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            game_rdata_q <= 2'b00;
        end else if (state_q == ST_GAME_ACCESS) begin
            game_rdata_q <= mem_rdata;
        end else begin
            game_rdata_q <= game_rdata_q;
        end
    end

    assign game.game_grant = grant_s;
    assign game.game_rdata = game_rdata_q;
    assign frame_tick      = frame_tick_q;
    assign game_data       = game_data_q;
    assign game_enable     = game_enable_q;
endmodule

// File: tb/tb_vga_grid_arbiter.sv
// Bench for vga_grid_arbiter: a line-skipping VGA tracker, a synchronous
// read-first grid RAM, randomized game traffic, and a frame-level ownership
// model that predicts every output each cycle.
module tb_vga_grid_arbiter;
    localparam int ADDR_W = 9;

    logic              clock_25 = 1'b0;
    logic              reset;
    logic [9:0]        X;
    logic [9:0]        Y;
    logic              display_area;
    logic              frame_tick;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [1:0]        mem_wdata;
    logic [1:0]        mem_rdata = 2'b00;
    logic [1:0]        game_data;
    logic              game_enable;

    int checks = 0;
    int fails  = 0;
    int frame_no = 0;
    int tick_cnt, we_cnt, post_rst_grants;
    bit rst_done, seen_grant;

    logic [1:0] ram [0:511];
    logic [1:0] exp_mem [0:511];
    logic       ram_ready = 1'b0;

    vga_grid_arbiter_if #(.ADDR_W(ADDR_W)) gif ();

    vga_grid_arbiter dut (
        .clock_25     (clock_25),
        .reset        (reset),
        .X            (X),
        .Y            (Y),
        .display_area (display_area),
        .game         (gif),
        .frame_tick   (frame_tick),
        .mem_addr     (mem_addr),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .game_data    (game_data),
        .game_enable  (game_enable)
    );

    always #5 clock_25 = ~clock_25;

    function automatic logic [1:0] init_val(input int i);
        if (i == 43) return 2'b10;
        if (i == 0)  return 2'b11;
        return 2'b00;
    endfunction

    // Grid RAM: synchronous read-first, one-cycle latency, preloaded once
    always @(posedge clock_25) begin
        if (!ram_ready) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
            ram_ready <= 1'b1;
        end else begin
            mem_rdata <= ram[mem_addr];
            if (mem_we) ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (frame %0d X=%0d Y=%0d)",
                     name, act, req, frame_no, X, Y);
        end
    endtask

    // Behavioural model and per-cycle comparison, sampled on the falling edge
    initial begin : compare
        bit blank_open, draining, session, tick_pend;
        bit en_p1, en_p2;
        logic [1:0] d_p1, d_p2, exp_rdata, rd_prev;
        for (int i = 0; i < 512; i++) exp_mem[i] = init_val(i);
        blank_open = 0; draining = 0; session = 0; tick_pend = 0;
        en_p1 = 0; en_p2 = 0; d_p1 = 0; d_p2 = 0; exp_rdata = 0; rd_prev = 0;
        forever begin
            @(negedge clock_25);
            if (!reset) begin
                chk("rst_grant", gif.game_grant, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_frame_tick", frame_tick, 0);
                chk("rst_game_enable", game_enable, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_game_data", game_data, 0);
                chk("rst_game_rdata", gif.game_rdata, 0);
                blank_open = 0; draining = 0; session = 0; tick_pend = 0;
                en_p1 = 0; en_p2 = 0; d_p1 = 0; d_p2 = 0; exp_rdata = 0; rd_prev = 0;
            end else begin
                int  xi, yi, pix, exp_addr;
                bit  guard, grid, fetch, exp_grant, exp_we;
                xi = int'(X); yi = int'(Y);
                pix   = ((yi / 32) * 20 + (xi / 32)) % 512;
                grid  = ((xi / 32) < 20) && ((yi / 32) < 15);
                guard = (yi == 524) && (xi >= 792);
                fetch = !blank_open;
                exp_grant = session && gif.game_req && !guard;
                exp_we    = exp_grant && gif.game_we;
                exp_addr  = blank_open ? int'(gif.game_addr) : pix;

                chk("game_grant", gif.game_grant, exp_grant);
                chk("mem_we", mem_we, exp_we);
                chk("mem_addr", mem_addr, exp_addr);
                chk("frame_tick", frame_tick, tick_pend);
                chk("game_enable", game_enable, en_p2);
                chk("game_data", game_data, d_p2);
                chk("game_rdata", gif.game_rdata, exp_rdata);
                if (exp_we) chk("mem_wdata", mem_wdata, gif.game_wdata);

                // Hand-computed anchors for the model
                if (xi == 98 && yi == 70) begin
                    chk("lit_cell43_data", game_data, 2'b10);
                    chk("lit_cell43_en", game_enable, 1);
                end
                if (xi == 162 && yi == 70)
                    chk("lit_cell45_data", game_data, (frame_no >= 2) ? 2'b01 : 2'b00);
                if (xi == 700 && yi == 70) chk("lit_offgrid_en", game_enable, 0);
                if (frame_tick === 1'b1) begin
                    chk("lit_tick_pos", {Y, X}, {10'd480, 10'd1});
                    tick_cnt++;
                end
                if (mem_we === 1'b1) we_cnt++;
                if (frame_no == 1) begin
                    if (gif.game_grant === 1'b1 && !seen_grant) begin
                        chk("lit_first_grant", {Y, X}, {10'd480, 10'd2});
                        seen_grant = 1;
                    end
                    if (xi == 791 && yi == 524) chk("lit_grant_791", gif.game_grant, 1);
                    if (xi == 792 && yi == 524) begin
                        chk("lit_revoke_792", gif.game_grant, 0);
                        chk("lit_revoke_we", mem_we, 0);
                    end
                    if (xi == 15 && yi == 481) chk("lit_rdata_addr0", gif.game_rdata, 2'b11);
                end
                if (frame_no == 4 && rst_done && gif.game_grant === 1'b1) post_rst_grants++;

                // Advance the model by one pixel clock
                if (session) exp_rdata = rd_prev;
                rd_prev = exp_mem[exp_addr];
                en_p2 = en_p1; d_p2 = d_p1;
                en_p1 = fetch && display_area && grid;
                d_p1  = (fetch && grid) ? exp_mem[pix] : 2'b00;
                if (exp_we) exp_mem[gif.game_addr] = gif.game_wdata;
                tick_pend = 0;
                if (blank_open) begin
                    if (guard) begin
                        blank_open = 0; draining = 1; session = 0;
                    end else begin
                        session = gif.game_req;
                    end
                end else if (draining) begin
                    if (xi == 799 && yi == 524) draining = 0;
                end else if (xi == 0 && yi == 480) begin
                    blank_open = 1; tick_pend = 1;
                end
            end
        end
    end

    // Apply one pixel's worth of tracker and game-port stimulus
    task automatic drive(input int f, input int y, input int x);
        X = 10'(x);
        Y = 10'(y);
        if (f == 3 || f == 5) display_area = (y < 480);
        else                  display_area = (x < 640) && (y < 480);
        gif.game_addr  = 9'(100 + $urandom_range(199, 0));
        gif.game_wdata = 2'($urandom);
        gif.game_we    = 1'($urandom);
        case (f)
            0: gif.game_req = 1'b0;
            1: begin
                gif.game_req = (y >= 100);
                gif.game_we  = 1'b0;
                if (y == 481 && x < 10) begin
                    gif.game_addr = 9'd45; gif.game_we = 1'b1; gif.game_wdata = 2'b01;
                end else if (y == 481 && x < 20) begin
                    gif.game_addr = 9'd0;
                end else if (y == 524 && x == 792) begin
                    gif.game_addr = 9'd46; gif.game_we = 1'b1; gif.game_wdata = 2'b11;
                end else begin
                    gif.game_we = 1'b0;
                end
            end
            2: begin
                gif.game_req = 1'b0; gif.game_we = 1'b0;
            end
            4: gif.game_req = 1'b1;
            default: if ($urandom_range(15, 0) == 0) gif.game_req = ~gif.game_req;
        endcase
    endtask

    initial begin : driver
        int lines [9];
        reset = 1'b0; X = 10'd0; Y = 10'd0; display_area = 1'b0;
        gif.game_req = 1'b0; gif.game_we = 1'b0; gif.game_addr = '0; gif.game_wdata = 2'b00;
        tick_cnt = 0; we_cnt = 0; post_rst_grants = 0; rst_done = 0; seen_grant = 0;
        repeat (4) @(posedge clock_25);
        #1 reset = 1'b1;
        for (int f = 0; f < 7; f++) begin
            frame_no = f; tick_cnt = 0; we_cnt = 0; post_rst_grants = 0;
            rst_done = 0; seen_grant = 0; gif.game_req = 1'b0;
            lines[0] = 0; lines[1] = 64; lines[2] = 70;
            lines[3] = (f == 1) ? 100 : int'($urandom_range(478, 100));
            lines[4] = 479; lines[5] = 480; lines[6] = 481;
            lines[7] = int'($urandom_range(523, 482)); lines[8] = 524;
            for (int li = 0; li < 9; li++) begin
                for (int x = 0; x < 800; x++) begin
                    @(posedge clock_25);
                    #1;
                    if (f == 4 && lines[li] == 481 && x == 304) reset = 1'b1;
                    drive(f, lines[li], x);
                    if (f == 4 && lines[li] == 481 && x == 300) begin
                        gif.game_we = 1'b1;
                        #1;
                        chk("grant_before_reset", gif.game_grant, 1);
                        chk("we_before_reset", mem_we, 1);
                        #1 reset = 1'b0;
                        rst_done = 1;
                        #1;
                        chk("grant_async_drop", gif.game_grant, 0);
                        chk("we_async_drop", mem_we, 0);
                    end
                end
            end
            @(negedge clock_25);
            #1;
            chk("ticks_per_frame", tick_cnt, 1);
            if (f == 0) chk("no_write_without_grant", we_cnt, 0);
            if (f == 1) chk("grant_seen_frame1", seen_grant, 1);
            if (f == 4) chk("no_grant_after_reset", post_rst_grants, 0);
        end
        begin
            int bad = 0;
            for (int i = 0; i < 512; i++) if (ram[i] !== exp_mem[i]) bad++;
            chk("ram_image", bad, 0);
        end
        chk("ram46_discarded_write", ram[46], 2'b00);
        chk("ram45_granted_write", ram[45], 2'b01);
        chk("ram43_preload_kept", ram[43], 2'b10);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
